// File: rtl/fp_divider.sv
// -----------------------------------------------------------------------------
// fp_divider
//   Multi-cycle IEEE-754 single-precision divider (Result = A / B).
//   A restoring mantissa divider produces one quotient bit per cycle.
//   The exponent is computed 8-bit modulo. The mantissa is truncated, not rounded.
//
//   Ports
//     clk      in   1  clock, all state updates on the rising edge
//     rst      in   1  synchronous active-high reset (aborts any operation)
//     start    in   1  divide request, sampled only while idle
//     A        in  32  dividend, captured on the accepting edge
//     B        in  32  divisor, captured on the accepting edge
//     Result   out 32  registered quotient, held until the next one is written
//     busy     out  1  high while dividing or normalising
//     done     out  1  one-cycle pulse in the cycle after Result is written
//     dz_flag  out  1  divide-by-zero, registered together with Result
//
//   Build option
//     FP_DIV_SPECIAL_EN : when defined, NaN, zero and infinity operands are
//                         recognised at normalisation time. When undefined,
//                         every operand is treated as a normalised number and
//                         dz_flag stays 0.
// -----------------------------------------------------------------------------
module fp_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] Result,
  output logic        busy,
  output logic        done,
  output logic        dz_flag
);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t      state_q, state_d;
  logic        sign_q, sign_d;
  logic [7:0]  exp_a_q, exp_a_d;
  logic [7:0]  exp_b_q, exp_b_d;
  logic [23:0] mb_q, mb_d;
  logic [25:0] rem_q, rem_d;
  logic [24:0] quo_q, quo_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] result_q, result_d;
  logic        dz_q, dz_d;
`ifdef FP_DIV_SPECIAL_EN
  logic        a_frac_nz_q, a_frac_nz_d;
`endif

  // Normalise the 25-bit quotient and pack the result. The quotient lies in
  // [2^23, 2^25). Its top bit selects which 23 bits form the mantissa and
  // selects the matching exponent bias. Low-order bits are dropped (truncation).
  function automatic logic [31:0] pack_quotient(input logic        s,
                                                input logic [7:0]  ea,
                                                input logic [7:0]  eb,
                                                input logic [24:0] q);
    logic [7:0]  e;
    logic [22:0] m;
    if (q[24]) begin
      e = ea - eb + 8'd127;
      m = q[23:1];
    end else begin
      e = ea - eb + 8'd126;
      m = q[22:0];
    end
    return {s, e, m};
  endfunction

  // One restoring step: a trial subtraction of the divisor from the partial
  // remainder. The remainder is always below 2*mB before the step, so
  // after any subtraction it fits in 25 bits. The left shift therefore
  // never loses a significant bit.
  logic        rem_ge;
  logic [25:0] rem_sub;

  always_comb begin
    rem_ge  = (rem_q >= {2'b00, mb_q});
    rem_sub = rem_ge ? (rem_q - {2'b00, mb_q}) : rem_q;
  end

`ifdef FP_DIV_SPECIAL_EN
  logic a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;

  always_comb begin
    a_zero = (exp_a_q == 8'h00);
    b_zero = (exp_b_q == 8'h00);
    a_inf  = (exp_a_q == 8'hFF) && !a_frac_nz_q;
    a_nan  = (exp_a_q == 8'hFF) &&  a_frac_nz_q;
    b_inf  = (exp_b_q == 8'hFF) && (mb_q[22:0] == 23'h0);
    b_nan  = (exp_b_q == 8'hFF) && (mb_q[22:0] != 23'h0);
  end
`endif

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    exp_a_d  = exp_a_q;
    exp_b_d  = exp_b_q;
    mb_d     = mb_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dz_d     = dz_q;
`ifdef FP_DIV_SPECIAL_EN
    a_frac_nz_d = a_frac_nz_q;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          sign_d  = A[31] ^ B[31];
          exp_a_d = A[30:23];
          exp_b_d = B[30:23];
          mb_d    = {1'b1, B[22:0]};
          rem_d   = {2'b00, 1'b1, A[22:0]};
          quo_d   = '0;
          cnt_d   = 5'd24;
`ifdef FP_DIV_SPECIAL_EN
          a_frac_nz_d = (A[22:0] != 23'h0);
`endif
          state_d = DIV;
        end
      end

      DIV: begin
        // Quotient bits enter at the LSB. After 25 steps the first bit,
        // q[24], has reached the MSB.
        quo_d = {quo_q[23:0], rem_ge};
        rem_d = rem_sub << 1;
        if (cnt_q == 5'd0) begin
          state_d = NORM;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end

      NORM: begin
        dz_d     = 1'b0;
        result_d = pack_quotient(sign_q, exp_a_q, exp_b_q, quo_q);
`ifdef FP_DIV_SPECIAL_EN
        if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
          result_d = 32'h7FC0_0000;
        end else if (b_zero) begin
          result_d = {sign_q, 8'hFF, 23'h0};
          dz_d     = 1'b1;
        end else if (a_zero || b_inf) begin
          result_d = {sign_q, 31'h0};
        end else if (a_inf) begin
          result_d = {sign_q, 8'hFF, 23'h0};
        end
`endif
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sign_q   <= 1'b0;
      exp_a_q  <= '0;
      exp_b_q  <= '0;
      mb_q     <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dz_q     <= 1'b0;
`ifdef FP_DIV_SPECIAL_EN
      a_frac_nz_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      exp_a_q  <= exp_a_d;
      exp_b_q  <= exp_b_d;
      mb_q     <= mb_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dz_q     <= dz_d;
`ifdef FP_DIV_SPECIAL_EN
      a_frac_nz_q <= a_frac_nz_d;
`endif
    end
  end

  assign Result = result_q;
  assign busy   = (state_q == DIV) || (state_q == NORM);
  assign done   = (state_q == DONE);
`ifdef FP_DIV_SPECIAL_EN
  assign dz_flag = dz_q;
`else
  assign dz_flag = 1'b0;
`endif

endmodule

// File: doc/fp_divider.md
FP_DIVIDER -- requirements
Module: fp_divider

Interface
REQ-001 The module SHALL have one clock and a synchronous, active-high reset.
REQ-002 Port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-003 Port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 Port start, input, 1 bit: request a divide; sampled only in IDLE.
REQ-005 Port A, input, 32 bits: IEEE-754 single-precision dividend; captured on the accepting edge.
REQ-006 Port B, input, 32 bits: IEEE-754 single-precision divisor; captured on the accepting edge.
REQ-007 Port Result, output, 32 bits: quotient, registered, held until the next accepted start.
REQ-008 Port busy, output, 1 bit: high while a divide is in progress.
REQ-009 Port done, output, 1 bit: one-cycle pulse when Result is updated.
REQ-010 Port dz_flag, output, 1 bit: divide-by-zero indication, registered with Result.

Function
REQ-011 The FSM SHALL have states IDLE, DIV, NORM and DONE; reset enters IDLE.
REQ-012 IDLE with start=1: capture A and B, set iteration counter to 24, go to DIV; IDLE with start=0: stay in IDLE.
REQ-013 Capture SHALL form sign = A[31]^B[31], mA = {1,A[22:0]} and mB = {1,B[22:0]}, and set remainder = mA (26-bit).
REQ-014 DIV SHALL perform one restoring step per cycle: if remainder >= mB, set quotient bit q[counter]=1 and subtract mB, else set the bit to 0; then shift the remainder left 1.
REQ-015 DIV SHALL run exactly 25 cycles (counter 24 down to 0), producing the 25-bit q = floor(mA*2^24/mB), then go to NORM.
REQ-016 In NORM with q[24]=1: mantissa = q[23:1], exp = eA - eB + 127.
REQ-017 In NORM with q[24]=0: mantissa = q[22:0], exp = eA - eB + 126.
REQ-018 Exponent arithmetic SHALL be 8-bit modulo, with no overflow or underflow detection; the mantissa SHALL be truncated, with no rounding.
REQ-019 NORM SHALL register Result = {sign, exp, mantissa} and go to DONE.
REQ-020 In DONE, done=1 for exactly that cycle, then the FSM returns to IDLE; a start in DONE is ignored.
REQ-021 busy SHALL be 1 in DIV and NORM and 0 in IDLE and DONE.
REQ-022 Latency: done SHALL be high in the 27th cycle after the cycle in which start was sampled.
REQ-023 start while busy or in DONE SHALL be ignored, and A/B changes during the operation SHALL have no effect.
REQ-024 Back-to-back operation: the earliest next accept is the IDLE cycle immediately following DONE.

Reset
REQ-025 rst=1 on a clock edge SHALL force IDLE and clear Result, busy, done, dz_flag, quotient, remainder and counter to 0; this takes priority over start.
REQ-026 Reset during DIV or NORM SHALL abort the operation, with no done pulse and Result=0.

Configuration
REQ-027 The macro FP_DIV_SPECIAL_EN SHALL compile special-operand handling in or out.
REQ-028 With FP_DIV_SPECIAL_EN defined, these cases apply, in priority order, at NORM (latency unchanged):
- A or B NaN (exp=FF, mantissa!=0), 0/0 or inf/inf -> Result 32'h7FC00000;
- B exp=0 -> Result {sign,8'hFF,23'h0} and dz_flag=1;
- A exp=0 or B inf -> Result {sign,31'h0};
- A inf -> Result {sign,8'hFF,23'h0}.
REQ-029 Without FP_DIV_SPECIAL_EN, all operands SHALL be treated as normalized per REQ-013..019, and dz_flag SHALL be constant 0.

Verification
REQ-030 A=40C00000 (6.0), B=40000000 (2.0), start=1 -> done 27 cycles later with Result=40400000 and busy low on done.
REQ-031 A=3F800000, B=40400000 -> Result=3EAAAAAA (truncated 1/3, q[24]=0 path).
REQ-032 A=C1000000 (-8.0), B=40000000 -> Result=C0800000.
REQ-033 With FP_DIV_SPECIAL_EN: A=3F800000, B=00000000 -> Result=7F800000 and dz_flag=1; A=B=00000000 -> Result=7FC00000.
REQ-034 start pulsed again at cycle 5 with different A/B -> ignored, and the first result is unchanged; rst at cycle 10 -> no done, all outputs 0, and a new start is accepted the next cycle.
